ex_alu_stage: RTL and testbench
===============================

Name: ex_alu_stage

Overview:
- Execute stage sitting directly downstream of ALU_Control in the RV32I datapath.
- Consumes the 4-bit ALU control code together with the operands, computes the result and the branch zero flag, and registers them toward MEM/writeback.
- Uses valid/ready handshakes on both sides, with a 2-entry skid buffer so that back-pressure never drops or reorders an operation.
- Flush support for branch redirects.

Parameters:
- XLEN, 32, operand/result width.
- RD_W, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  stage can accept an operation this cycle.
- alu_ctl  input  4  ALU control code from ALU_Control.
- op_a  input  XLEN  operand A (rs1).
- op_b  input  XLEN  operand B (rs2 or immediate).
- rd_in  input  RD_W  destination register index.
- is_branch  input  1  operation is a BEQ compare.
- flush  input  1  discard all held and incoming operations.
- out_valid  output  1  result register holds a valid operation.
- out_ready  input  1  downstream accepts the result this cycle.
- result  output  XLEN  ALU result.
- zero  output  1  result == 0.
- branch_taken  output  1  is_branch & zero.
- rd_out  output  RD_W  destination index for the held result.
- illegal  output  1  alu_ctl was not a supported code.

Behaviour:
- Supported codes:
  - 0000 AND: a&b.
  - 0001 OR: a|b.
  - 0010 ADD: a+b mod 2^XLEN.
  - 0110 SUB: a-b mod 2^XLEN.
  - 0111 SLT: signed a<b gives 1, else 0.
  - 1100 NOR: ~(a|b).
  - Any other code: result=0, illegal=1, zero=1, branch_taken=is_branch.
- Reset (synchronous, active-high): out_valid=0, skid_valid=0, result=0, rd_out=0, zero=0, branch_taken=0, illegal=0. in_ready=1 from the first cycle after reset.
- Accept condition: in_valid & in_ready at a rising edge. The operation is computed combinationally and captured at that edge. Latency is 1 cycle.
- in_ready = ~skid_valid, driven directly from a register with no combinational path from out_ready.
- Storage: output register OUT and skid register SKD. Each holds {result, zero, branch_taken, rd, illegal}.
- Per-edge transitions, priority order:
  1. reset or flush: out_valid=0, skid_valid=0, accepted input discarded.
  2. If out_valid & ~out_ready & accept: new operation goes to SKD, skid_valid=1, OUT unchanged.
  3. If (~out_valid | out_ready) & skid_valid: SKD moves to OUT, skid_valid=0. No accept is possible this cycle because in_ready=0.
  4. Else if (~out_valid | out_ready) & accept: new operation goes to OUT, out_valid=1.
  5. Else if out_ready & out_valid: out_valid=0.
- OUT fields are stable while out_valid & ~out_ready.
- Ordering is strictly FIFO. Throughput is 1 operation/cycle when out_ready is held high.
- Full condition: both registers valid, in_ready=0; hold until out_ready.
- flush and reset mid-operation drop both entries regardless of out_ready. Data fields may retain stale values; only the valid bits are cleared (reset also clears fields).
- SLT compares as two's complement. Add/sub wrap with no trap.

Optional Feature:
- ALU_OVF_EN.
- When defined: adds output port overflow (1 bit), registered alongside result. It is set on signed overflow of ADD (operand signs equal, result sign differs) and SUB (operand signs differ, result sign differs from a). It is 0 for all other codes, and reset value is 0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, out_ready=1 -> next cycle out_valid=1, result=0x80000000, zero=0, illegal=0; with ALU_OVF_EN, overflow=1.
- BEQ path: alu_ctl=0110, is_branch=1, a=b=0x1234 -> result=0, zero=1, branch_taken=1. Repeat with b=0x1235 -> result=0xFFFFFFFF, branch_taken=0.
- Back-pressure: stream AND, OR, SLT(a=0xFFFFFFFF, b=1) with out_ready=0 -> after 2 accepts in_ready=0 and OUT holds the AND result. Release out_ready -> results emerge in order AND, OR, SLT=1, none lost or duplicated.
- Flush with both entries full -> next cycle out_valid=0, in_ready=1. An operation presented in the flush cycle never appears at the output.
- Illegal code 1111 with a=5, b=3 -> result=0, illegal=1, zero=1.
- Reset asserted mid-stream with out_valid=1 -> next cycle all outputs at reset values, in_ready=1. The first operation after reset completes with 1-cycle latency.

Source files
------------

// File: rtl/ex_alu_stage.sv
// RV32I execute stage: ALU evaluation registered behind a valid/ready handshake with a 2-entry skid buffer.
// Optional signed-overflow output is built when ALU_OVF_EN is defined.
module ex_alu_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [RD_W-1:0] rd_in,
  input  logic            is_branch,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            branch_taken,
  output logic [RD_W-1:0] rd_out,
`ifdef ALU_OVF_EN
  output logic            overflow,
`endif
  output logic            illegal
);

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            zero;
    logic            bt;
    logic [RD_W-1:0] rd;
    logic            ill;
`ifdef ALU_OVF_EN
    logic            ovf;
`endif
  } entry_t;

  entry_t          out_q, skd_q, new_e;
  logic            out_vld_q, skd_vld_q;
  logic            accept, drain_ok;
  logic [XLEN-1:0] sum, diff, c_res;
  logic            c_ill;

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    c_res = '0;
    c_ill = 1'b0;
    case (alu_ctl)
      4'b0000: c_res = op_a & op_b;
      4'b0001: c_res = op_a | op_b;
      4'b0010: c_res = sum;
      4'b0110: c_res = diff;
      4'b0111: c_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b1100: c_res = ~(op_a | op_b);
      default: c_ill = 1'b1;
    endcase
  end

  always_comb begin
    new_e      = '0;
    new_e.res  = c_res;
    new_e.zero = (c_res == '0);
    new_e.bt   = is_branch & (c_res == '0);
    new_e.rd   = rd_in;
    new_e.ill  = c_ill;
`ifdef ALU_OVF_EN
    // ADD: equal operand signs, result sign flips; SUB: differing signs, result sign leaves a's
    case (alu_ctl)
      4'b0010: new_e.ovf = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
      4'b0110: new_e.ovf = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff[XLEN-1] != op_a[XLEN-1]);
      default: new_e.ovf = 1'b0;
    endcase
`endif
  end

  assign in_ready = ~skd_vld_q;
  assign accept   = in_valid & ~skd_vld_q;
  assign drain_ok = ~out_vld_q | out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld_q <= 1'b0;
      skd_vld_q <= 1'b0;
      out_q     <= '0;
      skd_q     <= '0;
    end else if (flush) begin
      out_vld_q <= 1'b0;
      skd_vld_q <= 1'b0;
    end else if (out_vld_q && !out_ready && accept) begin
      skd_q     <= new_e;
      skd_vld_q <= 1'b1;
    end else if (drain_ok && skd_vld_q) begin
      out_q     <= skd_q;
      out_vld_q <= 1'b1;
      skd_vld_q <= 1'b0;
    end else if (drain_ok && accept) begin
      out_q     <= new_e;
      out_vld_q <= 1'b1;
    end else if (out_ready && out_vld_q) begin
      out_vld_q <= 1'b0;
    end
  end

  assign out_valid    = out_vld_q;
  assign result       = out_q.res;
  assign zero         = out_q.zero;
  assign branch_taken = out_q.bt;
  assign rd_out       = out_q.rd;
  assign illegal      = out_q.ill;
`ifdef ALU_OVF_EN
  assign overflow     = out_q.ovf;
`endif

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed-vector bench for ex_alu_stage; expected values are hand-computed constants.
module tb_ex_alu_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, is_branch, flush, out_valid, out_ready;
  logic [3:0]  alu_ctl;
  logic [31:0] op_a, op_b, result;
  logic [4:0]  rd_in, rd_out;
  logic        zero, branch_taken, illegal;
`ifdef ALU_OVF_EN
  logic        overflow;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_alu_stage #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctl(alu_ctl), .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .is_branch(is_branch), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero),
    .branch_taken(branch_taken), .rd_out(rd_out),
`ifdef ALU_OVF_EN
    .overflow(overflow),
`endif
    .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic br);
    in_valid  = 1'b1;
    alu_ctl   = c;
    op_a      = a;
    op_b      = b;
    rd_in     = rd;
    is_branch = br;
  endtask

  // ctl, a, b, expected result
  logic [3:0]  t_ctl [6] = '{4'b0000, 4'b0001, 4'b1100, 4'b0110, 4'b0111, 4'b0111};
  logic [31:0] t_a   [6] = '{32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0,
                             32'h8000_0000, 32'h5};
  logic [31:0] t_b   [6] = '{32'hFF00_FF00, 32'h00FF_00FF, 32'h00FF_00FF, 32'h1,
                             32'h1, 32'h3};
  logic [31:0] t_exp [6] = '{32'hF000_F000, 32'h0FFF_0FFF, 32'hF000_F000, 32'hFFFF_FFFF,
                             32'h1, 32'h0};

  initial begin
    reset = 1'b1; in_valid = 1'b0; alu_ctl = 4'b0; op_a = '0; op_b = '0;
    rd_in = '0; is_branch = 1'b0; flush = 1'b0; out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {27'b0, zero, branch_taken, illegal, 2'b0}, 32'd0);
    chk("rst_rd", {27'b0, rd_out}, 32'd0);
    reset = 1'b0;

    // signed-overflowing add, 1-cycle latency
    drive(4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd3, 1'b0);
    step();
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_result", result, 32'h8000_0000);
    chk("add_zero_ill", {30'b0, zero, illegal}, 32'd0);
    chk("add_rd", {27'b0, rd_out}, 32'd3);
`ifdef ALU_OVF_EN
    chk("add_ovf", {31'b0, overflow}, 32'd1);
`endif
    in_valid = 1'b0;
    step();
    chk("add_drained", {31'b0, out_valid}, 32'd0);

    // BEQ taken then not taken, back-to-back
    drive(4'b0110, 32'h1234, 32'h1234, 5'd0, 1'b1);
    step();
    chk("beq_eq_result", result, 32'd0);
    chk("beq_eq_flags", {30'b0, zero, branch_taken}, 32'd3);
    op_b = 32'h1235;
    step();
    chk("beq_ne_valid", {31'b0, out_valid}, 32'd1);
    chk("beq_ne_result", result, 32'hFFFF_FFFF);
    chk("beq_ne_flags", {30'b0, zero, branch_taken}, 32'd0);
`ifdef ALU_OVF_EN
    chk("beq_ne_ovf", {31'b0, overflow}, 32'd0);
`endif

    // illegal code
    drive(4'b1111, 32'h5, 32'h3, 5'd7, 1'b0);
    step();
    chk("ill_result", result, 32'd0);
    chk("ill_flags", {29'b0, zero, branch_taken, illegal}, 32'b101);

    // opcode table, streamed at full rate
    for (int i = 0; i < 6; i++) begin
      drive(t_ctl[i], t_a[i], t_b[i], 5'(i + 10), 1'b0);
      step();
      chk($sformatf("op%0d_result", i), result, t_exp[i]);
      chk($sformatf("op%0d_ill_rd", i), {26'b0, illegal, rd_out}, {26'b0, 1'b0, 5'(i + 10)});
    end
    in_valid = 1'b0;
    step();

    // back-pressure: AND, OR, SLT with out_ready low
    out_ready = 1'b0;
    drive(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd1, 1'b0);
    step();
    chk("bp_first_ready", {31'b0, in_ready}, 32'd1);
    drive(4'b0001, 32'h0000_00F0, 32'h0000_000F, 5'd2, 1'b0);
    step();
    chk("bp_full_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_hold_and", result, 32'hF000_F000);
    drive(4'b0111, 32'hFFFF_FFFF, 32'h1, 5'd4, 1'b0);
    step();
    chk("bp_still_and", result, 32'hF000_F000);
    chk("bp_still_rd", {27'b0, rd_out}, 32'd1);
    chk("bp_still_full", {30'b0, out_valid, in_ready}, 32'b10);
    out_ready = 1'b1;
    step();
    chk("bp_or_result", result, 32'h0000_00FF);
    chk("bp_or_rd", {27'b0, rd_out}, 32'd2);
    chk("bp_or_ready", {30'b0, out_valid, in_ready}, 32'b11);
    step();
    in_valid = 1'b0;
    chk("bp_slt_result", result, 32'd1);
    chk("bp_slt_rd", {27'b0, rd_out}, 32'd4);
    step();
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    // flush with both entries full
    out_ready = 1'b0;
    drive(4'b0010, 32'd1, 32'd1, 5'd5, 1'b0);
    step();
    drive(4'b0010, 32'd2, 32'd2, 5'd6, 1'b0);
    step();
    chk("fl_full", {30'b0, out_valid, in_ready}, 32'b10);
    drive(4'b0010, 32'd9, 32'd9, 5'd7, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_cleared", {30'b0, out_valid, in_ready}, 32'b01);
    out_ready = 1'b1;
    step();
    chk("fl_nothing_out", {31'b0, out_valid}, 32'd0);

    // flush while an accept would otherwise land in the skid
    out_ready = 1'b0;
    drive(4'b0010, 32'd1, 32'd2, 5'd5, 1'b0);
    step();
    drive(4'b0010, 32'd3, 32'd4, 5'd6, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl2_cleared", {30'b0, out_valid, in_ready}, 32'b01);
    out_ready = 1'b1;
    step();
    chk("fl2_nothing_out", {31'b0, out_valid}, 32'd0);

    // reset mid-stream, then 1-cycle latency afterwards
    out_ready = 1'b0;
    drive(4'b0010, 32'd3, 32'd4, 5'd9, 1'b1);
    step();
    chk("mid_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_vr", {30'b0, out_valid, in_ready}, 32'b01);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_fields", {24'b0, zero, branch_taken, illegal, rd_out}, 32'd0);
    drive(4'b0010, 32'd10, 32'd20, 5'd8, 1'b0);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
    chk("post_rst_result", result, 32'd30);
    chk("post_rst_rd", {27'b0, rd_out}, 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
